perceptron_predict: RTL

//  Lookup side of the BST/perceptron branch predictor: reads the entry the update path writes, predicts.

---
 rtl/perceptron_predict.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/perceptron_predict.sv
// perceptron_predict
//   Lookup side of a BST/perceptron branch predictor. Owns the entry table
//   (2-bit status, 2-bit bias, GHR_LEN 3-bit weights per entry) and the
//   speculative global history register. A lookup takes two cycles:
//   S1 registers the table read and S2 registers the sum and the direction.
//   The prediction snapshot (old entry, GHR, |sum|) goes to EX, where the
//   update path writes the entry back through the wr_* port.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_valid, req_pc lookup request (index = req_pc[IDX_W+2:3])
//   stall             freeze S1, S2, outputs and the speculative GHR shift
//   flush             invalidate S1 and S2; a request in the same cycle is dropped
//   ghr_restore_en,   load GHR with corrected history (wins over the shift)
//   ghr_restore
//   wr_en, wr_pc,     entry write from the update path
//   wr_status, wr_bias, wr_weight
//   ready             low while the table is being cleared after reset
//   pred_*            prediction result, valid while pred_valid is high
//
// Handshake: a request is taken in any cycle where req_valid && ready &&
// !stall && !flush. Its result shows up two clock edges later with
// pred_valid high. If stall is high in that cycle, the result stays on the
// outputs until the first cycle in which stall is low. That unstalled cycle
// is the one in which the prediction counts as delivered. There is no
// backpressure beyond stall.
//
// Weight k (0-based) sits at wr_weight[3k+2:3k] and pairs with ghr[k].
// ghr[0] holds the newest outcome.

module perceptron_predict #(
    parameter int IDX_W   = 6,
    parameter int GHR_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [31:0]            req_pc,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   ghr_restore_en,
    input  logic [GHR_LEN-1:0]     ghr_restore,
    input  logic                   wr_en,
    input  logic [31:0]            wr_pc,
    input  logic [1:0]             wr_status,
    input  logic [1:0]             wr_bias,
    input  logic [3*GHR_LEN-1:0]   wr_weight,
    output logic                   ready,
    output logic                   pred_valid,
    output logic                   pred_taken,
    output logic [1:0]             pred_status,
    output logic [1:0]             pred_bias,
    output logic [3*GHR_LEN-1:0]   pred_weight,
    output logic [GHR_LEN-1:0]     pred_ghr,
    output logic [8:0]             pred_total_abs
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int WW      = 3 * GHR_LEN;
    localparam int EW      = 4 + WW;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   sweep;
    logic               run;

    logic [EW-1:0]      mem [ENTRIES];

    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic [EW-1:0]      wr_data;
    logic [EW-1:0]      rd_data;
    logic               accept;

    logic               s1_valid;
    logic [EW-1:0]      s1_entry;
    logic [1:0]         s1_status;
    logic [1:0]         s1_bias;
    logic [WW-1:0]      s1_weight;

    logic               s2_valid;
    logic               s2_taken;
    logic [1:0]         s2_status;
    logic [1:0]         s2_bias;
    logic [WW-1:0]      s2_weight;
    logic [GHR_LEN-1:0] s2_ghr;
    logic [8:0]         s2_abs;

    logic [GHR_LEN-1:0] ghr;
    logic [GHR_LEN-1:0] ghr_next;
    logic               shift_en;

    logic signed [8:0]  sum_c;
    logic               taken_c;
    logic [8:0]         abs_c;

    logic               unused;

    // Each weight is sign-extended to 4 bits before negation, so -(-4)
    // becomes +4 without wrapping.
    function automatic logic signed [8:0] calc_sum(
        input logic [1:0]         bias,
        input logic [WW-1:0]      w,
        input logic [GHR_LEN-1:0] g
    );
        logic signed [8:0] acc;
        logic signed [3:0] w4;
        logic signed [3:0] t;
        acc = {{7{bias[1]}}, bias};
        for (int k = 0; k < GHR_LEN; k++) begin
            w4  = {w[3*k+2], w[3*k +: 3]};
            t   = g[k] ? w4 : -w4;
            acc = acc + {{5{t[3]}}, t};
        end
        return acc;
    endfunction

    // ---------------- INIT/RUN state machine ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            sweep   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                sweep <= sweep + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (&sweep) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign run   = (state_q == ST_RUN);
    assign ready = run;

    // ---------------- entry table ----------------
    assign req_idx = req_pc[IDX_W+2:3];
    assign wr_idx  = wr_pc[IDX_W+2:3];
    assign wr_data = {wr_status, wr_bias, wr_weight};

    // The clear sweep owns the write port while INIT runs.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[sweep] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // A write to the same index in the same cycle is forwarded to the read.
    assign rd_data = (wr_en && run && (wr_idx == req_idx)) ? wr_data : mem[req_idx];
    assign accept  = req_valid && run && !stall && !flush;

    assign s1_status = s1_entry[EW-1:EW-2];
    assign s1_bias   = s1_entry[EW-3:EW-4];
    assign s1_weight = s1_entry[WW-1:0];

    // ---------------- speculative history ----------------
    // The shift happens at the end of the cycle in which a prediction is
    // delivered. S2 is loaded at that same edge, so the sum uses ghr_next.
    // That value is what the GHR register holds while the new prediction is
    // on the outputs.
    always_comb begin
        shift_en = s2_valid && !stall;
        ghr_next = ghr;
        if (ghr_restore_en) begin
            ghr_next = ghr_restore;
        end else if (shift_en) begin
            ghr_next = {ghr[GHR_LEN-2:0], s2_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else begin
            ghr <= ghr_next;
        end
    end

    // ---------------- sum and direction ----------------
    always_comb begin
        sum_c   = calc_sum(s1_bias, s1_weight, ghr_next);
        taken_c = 1'b0;
        case (s1_status)
            2'd1:    taken_c = 1'b1;
            2'd3:    taken_c = !sum_c[8];
            default: taken_c = 1'b0;
        endcase
        abs_c = sum_c[8] ? $unsigned(-sum_c) : $unsigned(sum_c);
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_entry  <= '0;
            s2_valid  <= 1'b0;
            s2_taken  <= 1'b0;
            s2_status <= '0;
            s2_bias   <= '0;
            s2_weight <= '0;
            s2_ghr    <= '0;
            s2_abs    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_entry <= rd_data;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_taken  <= taken_c;
                s2_status <= s1_status;
                s2_bias   <= s1_bias;
                s2_weight <= s1_weight;
                s2_ghr    <= ghr_next;
                s2_abs    <= abs_c;
            end
        end
    end

    assign pred_valid     = s2_valid;
    assign pred_taken     = s2_taken;
    assign pred_status    = s2_status;
    assign pred_bias      = s2_bias;
    assign pred_weight    = s2_weight;
    assign pred_ghr       = s2_ghr;
    assign pred_total_abs = s2_abs;

    // PC bits outside the index field do not take part in the lookup.
    assign unused = ^{req_pc[31:IDX_W+3], req_pc[2:0], wr_pc[31:IDX_W+3], wr_pc[2:0]};

endmodule
